// File: rtl/qsys_pio_gpio.sv
// Avalon-MM GPIO slave: per-bit direction, synchronised readback, sticky edge capture, level irq.
// Define PIO_BITSET_EN to add atomic OUTSET (addr 4) / OUTCLEAR (addr 5) write ports.
module qsys_pio_gpio #(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
`ifdef PIO_BITSET_EN
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
`endif

  // Arm counter: ARMING states 0..SYNC_STAGES, then ARMED holds.
  localparam int unsigned      ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARMED = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] prev_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] rise, fall, edge_raw, edge_det;
  logic [WIDTH-1:0] data_rd;
  logic [31:0]      rd_word;
  logic             armed;
  logic             unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wdata     = writedata[WIDTH-1:0];
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_cnt_q == ARMED);

  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  assign rise = sync_last & ~prev_q;
  assign fall = ~sync_last & prev_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    edge_raw = rise;
    case (EDGE_TYPE)
      1:       edge_raw = fall;
      2:       edge_raw = rise | fall;
      default: edge_raw = rise;
    endcase
  end

  // Flops still settling from reset would look like edges, so hold off until armed.
  assign edge_det = edge_raw & {WIDTH{armed}};

  always_comb begin
    arm_cnt_d = arm_cnt_q;
    if (!armed) arm_cnt_d = arm_cnt_q + ARM_W'(1);
  end

  always_comb begin
    data_out_d = data_out_q;
    oe_d       = oe_q;
    irqmask_d  = irqmask_q;
    capture_d  = capture_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_out_d = wdata;
        ADDR_DIR:      oe_d       = wdata;
        ADDR_IRQMASK:  irqmask_d  = wdata;
        ADDR_EDGECAP:  capture_d  = capture_q & ~wdata;
`ifdef PIO_BITSET_EN
        ADDR_OUTSET:   data_out_d = data_out_q | wdata;
        ADDR_OUTCLEAR: data_out_d = data_out_q & ~wdata;
`endif
        default: ;
      endcase
    end
    // A same-cycle edge overrides a write-1-to-clear.
    capture_d = capture_d | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      oe_q       <= '0;
      irqmask_q  <= '0;
      capture_q  <= '0;
      // NOTE: the synchroniser chain is reset too, so readback and edge logic start from known zeros.
      sync_q     <= '0;
      prev_q     <= '0;
      arm_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      data_out_q <= data_out_d;
      oe_q       <= oe_d;
      irqmask_q  <= irqmask_d;
      capture_q  <= capture_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q     <= sync_last;
      arm_cnt_q  <= arm_cnt_d;
    end
  end

  assign data_rd = (data_out_q & oe_q) | (sync_last & ~oe_q);

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:    rd_word[WIDTH-1:0] = data_rd;
      ADDR_DIR:     rd_word[WIDTH-1:0] = oe_q;
      ADDR_IRQMASK: rd_word[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: rd_word[WIDTH-1:0] = capture_q;
      default:      rd_word = '0;
    endcase
  end

  assign readdata = rd_word;
  assign out_port = data_out_q;
  assign oe       = oe_q;
  assign irq      = |(capture_q & irqmask_q);

endmodule

// File: tb/tb_qsys_pio_gpio.sv
// Directed bench for qsys_pio_gpio: register vector table plus hand-timed edge/clear/reset sequences.
module tb_qsys_pio_gpio;

  localparam int          W  = 8;
  localparam int          S  = 2;
  localparam logic [7:0]  RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = 8'hFF;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  in_val;
    int          settle;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  qsys_pio_gpio #(
    .WIDTH(W), .RESET_VALUE(RV), .SYNC_STAGES(S), .EDGE_TYPE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    logic [7:0] exp_set, exp_clr;
`ifdef PIO_BITSET_EN
    exp_set = 8'h81;
    exp_clr = 8'h80;
`else
    exp_set = 8'h00;
    exp_clr = 8'h00;
`endif
    //        wr    addr  wdata          in     settle exp_rd         out    oe     irq
    vecs[0] = '{1'b1, 3'd1, 32'h0000000F, 8'hFF, 0, 32'h0000000F, 8'hA5, 8'h0F, 1'b0};
    vecs[1] = '{1'b1, 3'd0, 32'h0000003C, 8'hC3, 3, 32'h000000CC, 8'h3C, 8'h0F, 1'b0};
    vecs[2] = '{1'b1, 3'd2, 32'h00000001, 8'hC3, 0, 32'h00000001, 8'h3C, 8'h0F, 1'b0};
    vecs[3] = '{1'b1, 3'd1, 32'hFFFFFFF0, 8'hC3, 0, 32'h000000F0, 8'h3C, 8'hF0, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 32'h00000000, 8'hC3, 0, 32'h00000033, 8'h3C, 8'hF0, 1'b0};
    vecs[5] = '{1'b0, 3'd3, 32'h00000000, 8'hC3, 0, 32'h00000000, 8'h3C, 8'hF0, 1'b0};
    vecs[6] = '{1'b1, 3'd7, 32'hFFFFFFFF, 8'hC3, 0, 32'h00000000, 8'h3C, 8'hF0, 1'b0};
    vecs[7] = '{1'b1, 3'd0, 32'hFFFFFF00, 8'hC3, 0, 32'h00000003, 8'h00, 8'hF0, 1'b0};
    vecs[8] = '{1'b1, 3'd4, 32'h00000081, 8'hC3, 0, 32'h00000000, exp_set, 8'hF0, 1'b0};
    vecs[9] = '{1'b1, 3'd5, 32'h00000001, 8'hC3, 0, 32'h00000000, exp_clr, 8'hF0, 1'b0};

    // Reset with inputs held high.
    cycles(3);
    check("rst out_port", {24'h0, out_port}, {24'h0, RV});
    check("rst oe", {24'h0, oe}, 32'h0);
    check("rst irq", {31'h0, irq}, 32'h0);
    rd_check("rst capture", 3'd3, 32'h0);
    reset_n = 1'b1;
    cycles(10);
    rd_check("armed capture", 3'd3, 32'h0);
    check("armed irq", {31'h0, irq}, 32'h0);
    rd_check("armed data", 3'd0, 32'h000000FF);

    for (int i = 0; i < 10; i++) begin
      in_port = vecs[i].in_val;
      if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdata);
      cycles(vecs[i].settle);
      rd_check($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].exp_rd);
      check($sformatf("vec%0d out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      check($sformatf("vec%0d oe", i), {24'h0, oe}, {24'h0, vecs[i].exp_oe});
      check($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
    end

    // Falling edge on bit 0 must not capture.
    in_port = 8'hC2;
    cycles(4);
    rd_check("fall no capture", 3'd3, 32'h0);

    // Rising edge: capture and irq exactly S+1 edges later.
    in_port = 8'hC3;
    cycles(S);
    rd_check("rise early cap", 3'd3, 32'h0);
    check("rise early irq", {31'h0, irq}, 32'h0);
    cycles(1);
    rd_check("rise cap", 3'd3, 32'h1);
    check("rise irq", {31'h0, irq}, 32'h1);

    // Clear collides with a fresh rising edge: edge wins.
    in_port = 8'hC2;
    cycles(4);
    rd_check("sticky cap", 3'd3, 32'h1);
    in_port = 8'hC3;
    cycles(1);
    wr_reg(3'd3, 32'h1);
    rd_check("collide cap", 3'd3, 32'h1);
    check("collide irq", {31'h0, irq}, 32'h1);
    wr_reg(3'd3, 32'h0);
    rd_check("w0 keeps cap", 3'd3, 32'h1);

    // Masking changes irq only.
    wr_reg(3'd2, 32'h0);
    check("masked irq", {31'h0, irq}, 32'h0);
    rd_check("masked cap", 3'd3, 32'h1);
    wr_reg(3'd2, 32'h1);
    check("unmasked irq", {31'h0, irq}, 32'h1);
    wr_reg(3'd3, 32'h1);
    rd_check("cleared cap", 3'd3, 32'h0);
    check("cleared irq", {31'h0, irq}, 32'h0);

    // Async reset while all bits captured.
    in_port = 8'h00;
    cycles(4);
    in_port = 8'hFF;
    cycles(4);
    rd_check("all cap", 3'd3, 32'h000000FF);
    check("all irq", {31'h0, irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async irq", {31'h0, irq}, 32'h0);
    check("async out", {24'h0, out_port}, {24'h0, RV});
    check("async oe", {24'h0, oe}, 32'h0);
    rd_check("async cap", 3'd3, 32'h0);
    cycles(2);
    reset_n = 1'b1;
    cycles(10);
    rd_check("rearm cap", 3'd3, 32'h0);
    check("rearm irq", {31'h0, irq}, 32'h0);
    rd_check("rearm data", 3'd0, 32'h000000FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
